// File: rtl/seq_mul_add_pkg.sv
// Shared types and constants for the sequential multiply-add.
// Contents: FSM state enum, default operand width, default counter width.
package seq_mul_add_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul_add_if.sv
// Request/result bundle for seq_mul_add.
// start/a/b/c flow master->slave; result/busy/done flow slave->master.
interface seq_mul_add_if
  import seq_mul_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   c;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic               done;

  modport master (output start, a, b, c, input result, busy, done);
  modport slave  (input start, a, b, c, output result, busy, done);

endinterface

// File: rtl/seq_mul_add_step.sv
// One shift-add step: conditionally add the multiplicand, then shift.
// Ports: acc/mcand (2*WIDTH), mplier (WIDTH) in; *_nxt the stepped values out.
module seq_mul_add_step
  import seq_mul_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplier_nxt
);

  // Sum cannot exceed 2^(2W) - 2^W, so the 2W-bit add never wraps.
  assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_nxt  = mcand << 1;
  assign mplier_nxt = mplier >> 1;

endmodule

// File: rtl/seq_mul_add.sv
// Sequential unsigned result = a*b + c, one multiplier bit per clock.
// Ports: clk, rst (async active-high), bus (slave: start/a/b/c in,
// result/busy/done out). Fixed latency: WIDTH RUN cycles plus DONE.
module seq_mul_add
  import seq_mul_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  seq_mul_add_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               state, state_d;
  logic [2*WIDTH-1:0]   acc, acc_d;
  logic [2*WIDTH-1:0]   mcand, mcand_d;
  logic [WIDTH-1:0]     mplier, mplier_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   mcand_step;
  logic [WIDTH-1:0]     mplier_step;

  seq_mul_add_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_nxt    (acc_step),
    .mcand_nxt  (mcand_step),
    .mplier_nxt (mplier_step)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      acc      <= acc_d;
      mcand    <= mcand_d;
      mplier   <= mplier_d;
      cnt      <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state;
    acc_d    = acc;
    mcand_d  = mcand;
    mplier_d = mplier;
    cnt_d    = cnt;
    result_d = result_q;
    // busy/done are registered copies of the state decode, one cycle behind.
    busy_d   = (state == RUN) || (state == DONE);
    done_d   = (state == DONE);

    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_d    = {{WIDTH{1'b0}}, bus.c};
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_step;
        mplier_d = mplier_step;
        cnt_d    = cnt + CNT_W'(1);
        // No early exit on mplier==0: latency stays fixed.
        if (cnt == CNT_W'(WIDTH - 1)) begin
          result_d = acc_step;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_seq_mul_add.sv
// Self-checking bench for seq_mul_add (WIDTH=32): directed vector table
// plus hand-written sequences for back-to-back, abort and ignored-start cases.
module tb_seq_mul_add;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 1;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [2*W-1:0] exp;
    string          name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  seq_mul_add_if #(.WIDTH(W)) bus ();

  seq_mul_add #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Launch one operation from IDLE (called #1 after a posedge) and check it.
  task automatic run_op(input vec_t v);
    int lat;
    bit busy_ok;
    bus.a = v.a; bus.b = v.b; bus.c = v.c; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= LAT + 8 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (bus.busy !== (n <= LAT)) busy_ok = 1'b0;
      if (bus.done === 1'b1) lat = n;
    end
    chk({v.name, " latency"}, 64'(lat), 64'(LAT));
    chk({v.name, " result"}, bus.result, v.exp);
    chk({v.name, " busy window"}, 64'(busy_ok), 64'd1);
    @(posedge clk); #1;
    chk({v.name, " done one cycle"}, 64'(bus.done), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int d1, d2, ndone, dcyc;
    logic [2*W-1:0] r1, r2;

    vecs[0] = '{32'd126, 32'd10, 32'd5, 64'd1265, "basic"};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_00000000, "all_ones"};
    vecs[2] = '{32'd0, 32'h12345678, 32'hDEADBEEF, 64'h00000000_DEADBEEF, "a_zero"};
    vecs[3] = '{32'h12345678, 32'd0, 32'd0, 64'd0, "b_zero"};
    vecs[4] = '{32'hFFFFFFFF, 32'd1, 32'd0, 64'h00000000_FFFFFFFF, "b_one"};
    vecs[5] = '{32'h80000000, 32'h80000000, 32'd1, 64'h40000000_00000001, "msb"};

    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", bus.result, 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i]);

    // start held high: back-to-back runs; mid-run operand change hits only the next run.
    bus.a = 32'd7; bus.b = 32'd9; bus.c = 32'd1; bus.start = 1'b1;
    d1 = 0; d2 = 0; r1 = '0; r2 = '0;
    for (int n = 0; n <= 90; n++) begin
      @(posedge clk); #1;
      if (n == 5) begin bus.a = 32'd1000; bus.b = 32'd1000; bus.c = 32'd999; end
      if (bus.done === 1'b1) begin
        if (d1 == 0) begin d1 = n; r1 = bus.result; end
        else if (d2 == 0) begin d2 = n; r2 = bus.result; bus.start = 1'b0; end
      end
    end
    bus.start = 1'b0;
    chk("b2b first done edge", 64'(d1), 64'(LAT));
    chk("b2b spacing", 64'(d2 - d1), 64'(W + 2));
    chk("b2b first result", r1, 64'd64);
    chk("b2b second result", r2, 64'd1000999);

    // Asynchronous reset in the middle of a run.
    bus.a = 32'd3; bus.b = 32'd4; bus.c = 32'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort result", bus.result, 64'd0);
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);
    run_op('{32'd126, 32'd10, 32'd5, 64'd1265, "after_abort"});

    // start pulsed during RUN must be ignored.
    bus.a = 32'd3; bus.b = 32'd5; bus.c = 32'd2; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0; dcyc = 0; r1 = '0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (n == 10) begin
        bus.a = 32'd100; bus.b = 32'd100; bus.c = 32'd0; bus.start = 1'b1;
      end
      if (bus.done === 1'b1) begin
        ndone++;
        if (dcyc == 0) begin dcyc = n; r1 = bus.result; end
      end
    end
    bus.start = 1'b0;
    chk("ignored start done count", 64'(ndone), 64'd1);
    chk("ignored start done edge", 64'(dcyc), 64'(LAT));
    chk("ignored start result", r1, 64'd17);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_mul_add.md
Name: seq_mul_add

Overview:
Sequential unsigned multiply-add that computes result = a*b + c with a shift-add datapath, one multiplier bit per clock.
It is the inverse of the team's 32-bit sequential divider. Feeding it quotient, divisor and remainder rebuilds the dividend, which closes the loop on divider test benches.
It has the same start/finish style as the divider, so a finish pulse can drive a 32-bit register enable directly.

Parameters:
WIDTH, 32, operand width in bits; result is 2*WIDTH bits.

Ports:
clk     input   1          system clock, all state on rising edge
rst     input   1          asynchronous, active-high reset
start   input   1          request; sampled only in IDLE
a       input   WIDTH      multiplicand (e.g. quotient), unsigned
b       input   WIDTH      multiplier (e.g. divisor), unsigned
c       input   WIDTH      addend (e.g. remainder), unsigned
result  output  2*WIDTH    a*b + c, registered, held until next completion
busy    output  1          high in RUN and DONE
done    output  1          one-cycle pulse when result updates

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; result=0, busy=0, done=0.
  - Internal accumulator, shift registers and counter cleared.
  - A reset during RUN aborts the operation; no done pulse and no result update follow.
- Arithmetic:
  - All operations unsigned.
  - Max value (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W fits in 2W bits, so overflow is impossible.
  - The accumulator is 2W bits wide and the multiplicand shift register is 2W bits wide.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at the edge: latch acc={W'0,c}, mcand={W'0,a}, mplier=b, cnt=0; go to RUN.
  - Else stay in IDLE.
- RUN, one step per cycle:
  - If mplier[0]: acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, cnt++.
  - At the step where cnt==WIDTH-1, go to DONE and load result with the final acc value.
  - Exactly WIDTH RUN cycles; no early termination on mplier==0, so latency is fixed.
- DONE: done=1 for this cycle only, busy=1; go to IDLE unconditionally.
- Latency:
  - start sampled at edge 0; done high during the cycle after edge WIDTH+1; result valid in that same cycle.
  - With start tied high, a new operation launches every WIDTH+2 cycles (34 cycles for W=32).
- Input and handshake rules:
  - start during RUN or DONE is ignored.
  - Changes to a/b/c after the launch edge have no effect.
- result changes only on the DONE transition; it is stable at all other times.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN, DONE};
  - default WIDTH constant of 32;
  - counter width constant, $clog2(WIDTH).
- One natural sub-module, mul_add_step: the combinational step that takes (acc, mcand, mplier) and returns the next (acc, mcand, mplier).
- The FSM, counter and result register stay in seq_mul_add.

Test Plan:
- a=126, b=10, c=5, single start pulse -> done pulse in cycle 33 after launch edge; result=64'd1265 (0x4F1); busy high cycles 1..33.
- a=b=c=32'hFFFFFFFF -> result=64'hFFFFFFFF_00000000; no wrap.
- a=0, b=32'h12345678, c=32'hDEADBEEF -> result=64'h00000000_DEADBEEF; a=32'h12345678, b=0, c=0 -> result=0; latency still 33 cycles.
- start tied high, operands changed between runs (7*9+1, then 1000*1000+999) -> done pulses exactly 34 cycles apart; results 64 and 1000999. An operand change mid-RUN does not alter the in-flight result.
- rst asserted asynchronously mid-RUN (cycle 15) -> result, busy and done go to 0 immediately; no done afterwards; a fresh start after release gives the correct result.
- start pulsed at cycle 10 of a run -> ignored; exactly one done pulse, and the result belongs to the first operands.
